// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: FSM states, default
// parameter values and the address-alignment helper.
package pc_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_e;

  localparam int unsigned PC_WIDTH_DEF     = 32;
  localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VEC_DEF   = 32'h0000_0004;
  localparam int unsigned PC_STEP_DEF      = 4;

  // Clears the log2(step) low bits; step must be a power of two.
  // Works on a 64-bit container so callers of any width up to 64 can share it.
  function automatic logic [63:0] align(input logic [63:0] addr,
                                        input int unsigned step);
    logic [63:0] mask;
    mask = 64'(step) - 64'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending redirect target holder: capture (overwrites any held
// target), clear, valid flag and target output.
module pc_redirect_buf
  #(
    parameter int unsigned WIDTH = 32
  )
  (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_capture,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_target,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_target
  );

  logic             r_valid;
  logic [WIDTH-1:0] r_target;

  // Capture has priority over clear; the newest target always replaces the old one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_target <= '0;
    end else if (i_capture) begin
      r_valid  <= 1'b1;
      r_target <= i_target;
    end else if (i_clear) begin
      r_valid  <= 1'b0;
    end
  end

  assign o_valid  = r_valid;
  assign o_target = r_target;

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential advance, stall hold, branch/jump
// redirects with a one-entry pending buffer, exception entry and return.
// Exception/eret logic and the epc register are built only when
// PC_UNIT_EXC_EN is defined; otherwise those inputs are ignored and epc is 0.
module pc_unit
  import pc_pkg::*;
  #(
    parameter int unsigned      WIDTH     = PC_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC_DEF),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC_DEF),
    parameter int unsigned      STEP      = PC_STEP_DEF
  )
  (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] pc,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             exc_valid,
    input  logic [WIDTH-1:0] exc_pc,
    input  logic             eret_valid,
    output logic [WIDTH-1:0] epc,
    output logic             redirect_pending
  );

  pc_state_e        r_state;
  pc_state_e        w_state_next;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_pc_aligned;
  logic             w_pc_load;
  logic             w_advance;
  logic             w_capture;
  logic             w_clear;
  logic             w_pend_valid;
  logic [WIDTH-1:0] w_pend_target;
  logic             w_exc_take;
  logic             w_eret_take;
  logic [WIDTH-1:0] w_epc;

`ifdef PC_UNIT_EXC_EN
  logic [WIDTH-1:0] r_epc;
  logic             w_epc_load;

  assign w_exc_take  = exc_valid;
  assign w_eret_take = eret_valid;
  assign w_epc       = r_epc;

  // Saved exception PC; only exception entry writes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_epc <= '0;
    else if (w_epc_load) r_epc <= exc_pc;
  end
`else
  logic w_unused_exc;

  assign w_exc_take   = 1'b0;
  assign w_eret_take  = 1'b0;
  assign w_epc        = '0;
  assign w_unused_exc = ^{exc_valid, exc_pc, eret_valid};
`endif

  // BOOT lasts exactly one cycle after reset; RUN is held until the next reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= BOOT;
    else     r_state <= w_state_next;
  end

  // Next-state logic for the boot sequencer.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      BOOT:    w_state_next = RUN;
      RUN:     w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  assign fetch_valid = (r_state == RUN);
  assign w_advance   = fetch_valid & fetch_ready & ~stall;

  // Priority-ordered choice of the next pc and pending-buffer action.
  always_comb begin
    w_pc_load = 1'b0;
    w_pc_next = r_pc;
    w_capture = 1'b0;
    w_clear   = 1'b0;
`ifdef PC_UNIT_EXC_EN
    w_epc_load = 1'b0;
`endif
    if (w_exc_take) begin
      w_pc_load = 1'b1;
      w_pc_next = EXC_VEC;
      w_clear   = 1'b1;
`ifdef PC_UNIT_EXC_EN
      w_epc_load = 1'b1;
`endif
    end else if (w_eret_take) begin
      w_pc_load = 1'b1;
      w_pc_next = w_epc;
      w_clear   = 1'b1;
    end else if (redirect_valid && w_advance) begin
      w_pc_load = 1'b1;
      w_pc_next = redirect_target;
      w_clear   = 1'b1;
    end else if (redirect_valid) begin
      w_capture = 1'b1;
    end else if (w_advance && w_pend_valid) begin
      w_pc_load = 1'b1;
      w_pc_next = w_pend_target;
      w_clear   = 1'b1;
    end else if (w_advance) begin
      w_pc_load = 1'b1;
      w_pc_next = r_pc + WIDTH'(STEP);
    end
  end

  // Alignment applies only on load so an unaligned RESET_VEC survives a hold.
  assign w_pc_aligned = WIDTH'(align(64'(w_pc_next), STEP));

  // Fetch address register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_pc <= RESET_VEC;
    else if (w_pc_load) r_pc <= w_pc_aligned;
  end

  pc_redirect_buf #(.WIDTH(WIDTH)) u_redirect_buf (
    .clk      (clk),
    .rst      (rst),
    .i_capture(w_capture),
    .i_clear  (w_clear),
    .i_target (redirect_target),
    .o_valid  (w_pend_valid),
    .o_target (w_pend_target)
  );

  assign pc               = r_pc;
  assign epc              = w_epc;
  assign redirect_pending = w_pend_valid;

endmodule

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit with default parameters.
// Expected values follow PC_UNIT_EXC_EN when that macro is defined.
module tb_pc_unit;

`ifdef PC_UNIT_EXC_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        stall;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exc_valid;
  logic [31:0] exc_pc;
  logic        eret_valid;
  logic [31:0] epc;
  logic        redirect_pending;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        stall;
    logic        fr;
    logic        rv;
    logic [31:0] rt;
    logic        xv;
    logic [31:0] xpc;
    logic        ev;
    logic [31:0] exp_pc;
    logic [31:0] exp_epc;
    logic        exp_pend;
    logic        exp_fv;
  } vec_t;

  vec_t vecs[$];

  pc_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .fetch_ready     (fetch_ready),
    .fetch_valid     (fetch_valid),
    .pc              (pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .exc_valid       (exc_valid),
    .exc_pc          (exc_pc),
    .eret_valid      (eret_valid),
    .epc             (epc),
    .redirect_pending(redirect_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic fr, input logic rv,
                              input logic [31:0] rt, input logic xv,
                              input logic [31:0] xpc, input logic ev,
                              input logic [31:0] epc_v, input logic [31:0] eepc,
                              input logic pend);
    vec_t v;
    v.stall = st; v.fr = fr; v.rv = rv; v.rt = rt; v.xv = xv; v.xpc = xpc;
    v.ev = ev; v.exp_pc = epc_v; v.exp_epc = eepc; v.exp_pend = pend;
    v.exp_fv = 1'b1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    stall           = v.stall;
    fetch_ready     = v.fr;
    redirect_valid  = v.rv;
    redirect_target = v.rt;
    exc_valid       = v.xv;
    exc_pc          = v.xpc;
    eret_valid      = v.ev;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; stall = 1'b0; fetch_ready = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; exc_valid = 1'b0; exc_pc = '0; eret_valid = 1'b0;

    //              st  fr  rv  rt            xv  xpc    ev  pc                          epc                      pend
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 32'h0,                      32'h0,                   0)); // 0 BOOT->RUN
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 32'h4,                      32'h0,                   0)); // 1
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 32'h8,                      32'h0,                   0)); // 2
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 32'hC,                      32'h0,                   0)); // 3
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 32'h10,                     32'h0,                   0)); // 4
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,  0, 32'h10,                     32'h0,                   0)); // 5 stall
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,  0, 32'h10,                     32'h0,                   0)); // 6
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,  0, 32'h10,                     32'h0,                   0)); // 7
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 32'h14,                     32'h0,                   0)); // 8
    vecs.push_back(mk(0, 0, 1, 32'h200,      0, 32'h0,  0, 32'h14,                     32'h0,                   1)); // 9 busy redirect
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 32'h200,                    32'h0,                   0)); // 10 consume
    vecs.push_back(mk(1, 1, 1, 32'h100,      0, 32'h0,  0, 32'h200,                    32'h0,                   1)); // 11
    vecs.push_back(mk(1, 1, 1, 32'h300,      0, 32'h0,  0, 32'h200,                    32'h0,                   1)); // 12 overwrite
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 32'h300,                    32'h0,                   0)); // 13
    vecs.push_back(mk(1, 1, 1, 32'h500,      0, 32'h0,  0, 32'h300,                    32'h0,                   1)); // 14
    vecs.push_back(mk(1, 1, 0, 32'h0,        1, 32'h48, 0, EXC ? 32'h4  : 32'h300,     EXC ? 32'h48 : 32'h0,    !EXC)); // 15 exc
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,  1, EXC ? 32'h48 : 32'h300,     EXC ? 32'h48 : 32'h0,    !EXC)); // 16 eret
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, EXC ? 32'h4C : 32'h500,     EXC ? 32'h48 : 32'h0,    0)); // 17
    vecs.push_back(mk(0, 1, 1, 32'hFFFFFFFC, 0, 32'h0,  0, 32'hFFFFFFFC,               EXC ? 32'h48 : 32'h0,    0)); // 18
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 32'h0,                      EXC ? 32'h48 : 32'h0,    0)); // 19 wrap
    vecs.push_back(mk(0, 1, 1, 32'h203,      0, 32'h0,  0, 32'h200,                    EXC ? 32'h48 : 32'h0,    0)); // 20 align
    vecs.push_back(mk(0, 0, 1, 32'h407,      0, 32'h0,  0, 32'h200,                    EXC ? 32'h48 : 32'h0,    1)); // 21
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 32'h404,                    EXC ? 32'h48 : 32'h0,    0)); // 22 aligned pending
    vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h88, 1, EXC ? 32'h4  : 32'h408,     EXC ? 32'h88 : 32'h0,    0)); // 23 exc beats eret
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  1, EXC ? 32'h88 : 32'h40C,     EXC ? 32'h88 : 32'h0,    0)); // 24 eret

    repeat (2) @(posedge clk);
    #1;
    check("reset_pc",   pc, 32'h0);
    check("reset_epc",  epc, 32'h0);
    check("reset_fv",   32'(fetch_valid), 32'h0);
    check("reset_pend", 32'(redirect_pending), 32'h0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_pc", i),   pc, vecs[i].exp_pc);
      check($sformatf("v%0d_epc", i),  epc, vecs[i].exp_epc);
      check($sformatf("v%0d_pend", i), 32'(redirect_pending), 32'(vecs[i].exp_pend));
      check($sformatf("v%0d_fv", i),   32'(fetch_valid), 32'(vecs[i].exp_fv));
      @(negedge clk);
    end

    // Asynchronous reset between edges discards a pending redirect at once.
    stall = 1'b0; fetch_ready = 1'b0; redirect_valid = 1'b1;
    redirect_target = 32'h600; exc_valid = 1'b0; eret_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_pend", 32'(redirect_pending), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pend", 32'(redirect_pending), 32'h0);
    check("async_rst_pc",   pc, 32'h0);
    check("async_rst_epc",  epc, 32'h0);
    check("async_rst_fv",   32'(fetch_valid), 32'h0);

    // Exception taken in BOOT, then sequential advance from the handler.
    @(negedge clk);
    rst = 1'b0; redirect_valid = 1'b0; fetch_ready = 1'b1;
    exc_valid = 1'b1; exc_pc = 32'h30;
    @(posedge clk);
    #1;
    check("boot_exc_pc",  pc, EXC ? 32'h4 : 32'h0);
    check("boot_exc_epc", epc, EXC ? 32'h30 : 32'h0);
    check("boot_exc_fv",  32'(fetch_valid), 32'h1);
    @(negedge clk);
    exc_valid = 1'b0;
    @(posedge clk);
    #1;
    check("boot_exc_adv", pc, EXC ? 32'h8 : 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the fetch stage of the pipelined MIPS core. It holds the current fetch address, advances it by a fixed step when instruction memory accepts a fetch, and handles stalls, branch/jump redirects and exception entry/return. A one-entry pending-redirect buffer ensures a redirect that arrives during a stall or while memory is busy is never lost.

## Interface
- WIDTH, 32, address width in bits
- RESET_VEC, 0, PC value loaded by reset
- EXC_VEC, 32'h0000_0004, exception handler entry address
- STEP, 4, sequential increment; power of two ≥ 1

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hazard hold from decode; blocks sequential advance
- fetch_ready  in  1  instruction memory accepts the current address
- fetch_valid  out  1  pc is a valid fetch request
- pc  out  WIDTH  current fetch address
- redirect_valid  in  1  branch/jump taken
- redirect_target  in  WIDTH  branch/jump target
- exc_valid  in  1  exception raised
- exc_pc  in  WIDTH  address of faulting instruction
- eret_valid  in  1  return from exception
- epc  out  WIDTH  saved exception PC
- redirect_pending  out  1  pending-redirect buffer occupied

## Operation
- States: BOOT, RUN. Reset enters BOOT. BOOT moves to RUN on the next clock edge unconditionally. RUN persists until reset.
- fetch_valid = (state == RUN).
- advance = fetch_valid & fetch_ready & ~stall.
- The event with the highest priority wins each cycle:
  1. exc_valid: pc ← EXC_VEC; epc ← exc_pc; pending cleared. Applies regardless of stall or fetch_ready, and also in BOOT.
  2. eret_valid: pc ← epc; pending cleared. Applies regardless of stall or fetch_ready.
  3. redirect_valid with advance: pc ← redirect_target; pending cleared.
  4. redirect_valid without advance: pending ← redirect_target. If the buffer is already full, the newest target overwrites it. pc holds.
  5. advance with pending set: pc ← pending target; pending cleared.
  6. advance alone: pc ← pc + STEP, modulo 2^WIDTH.
  7. Otherwise every register holds.
- Every value loaded into pc has its log2(STEP) low bits forced to zero. Exception to this rule: RESET_VEC is loaded as given.
- epc changes only on exc_valid.

## Timing
- Reset values: pc = RESET_VEC, epc = 0, fetch_valid = 0, redirect_pending = 0, state = BOOT.
- Reset is asynchronous. Asserting it mid-operation discards any pending redirect immediately.
- First fetch_valid is seen 1 cycle after reset release.
- All updates happen on the rising edge, with 1-cycle latency from inputs to pc.
- The unit has no combinational path from inputs to pc or epc. fetch_valid depends only on state.
- redirect_pending is registered. It is high from the cycle after capture until the cycle after it is consumed or cleared.
- When exc_valid and eret_valid are asserted together, exc_valid wins.

## Configuration
- Macro PC_UNIT_EXC_EN.
- Defined: exception and eret logic as described above.
- Undefined: exc_valid, exc_pc and eret_valid are ignored, epc is constant 0, and no epc register is generated. The port list is unchanged.

## Structure
- Shared package pc_pkg holds:
  - state enum (BOOT, RUN)
  - default RESET_VEC, EXC_VEC and STEP constants
  - align function that clears the low bits
- Sub-module pc_redirect_buf is the one-entry pending-target holder. It provides capture/overwrite/clear, a valid flag and a target output.

## Test plan
- Reset release with fetch_ready=1, stall=0 → pc = 0 in BOOT, then 0, 4, 8, 12 on successive cycles. fetch_valid rises 1 cycle after release.
- stall=1 for 3 cycles at pc=0x10 → pc holds 0x10. After stall drops, pc becomes 0x14.
- redirect_valid with target 0x200 while fetch_ready=0 → redirect_pending=1 and pc holds. When fetch_ready=1, pc becomes 0x200 and pending clears.
- Two redirects during a stall (0x100, then 0x300) → after the stall, pc becomes 0x300.
- exc_valid with exc_pc=0x48 during a stall, while a redirect is pending → pc becomes 0x4, epc becomes 0x48, pending clears. Later eret_valid → pc becomes 0x48. Without PC_UNIT_EXC_EN, pc is unaffected and epc stays 0.
- pc = 0xFFFF_FFFC with advance → pc becomes 0. redirect_target 0x203 with STEP=4 → pc becomes 0x200.
